// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit queue
package uart_pkg;

  // Issue FSM states
  typedef enum logic [1:0] {
    Q_IDLE      = 2'd0,
    Q_WAIT_BUSY = 2'd1,
    Q_WAIT_DONE = 2'd2
  } q_state_t;

  // Cycles to wait for the transmitter to acknowledge a start pulse
  localparam int WAIT_BUSY_LIMIT = 2;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered count/full/empty
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_nxt;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO may still accept a push
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Next occupancy, shared by count and the full/empty flags
  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (do_push && !do_pop)
      count_nxt = count + ONE;
    else if (!do_push && do_pop)
      count_nxt = count - ONE;
  end

  // Storage array, no reset so it maps onto distributed RAM
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH; flags are registered from count_nxt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push)
          wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)
          rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte queue and issue FSM feeding the UART transmitter
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [7:0]     wr_data,
  input  logic           flush,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count,
  output logic           overflow,
  input  logic           ovf_clr,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_busy
);

  localparam logic [1:0] WAIT_LAST = 2'(WAIT_BUSY_LIMIT - 1);

  q_state_t   state;
  logic [1:0] wait_cnt;
  logic [7:0] head;
  logic       pop;
  logic       ovf_set;

  // Only IDLE issues, and never while a flush is discarding the queue
  assign pop     = (state == Q_IDLE) && !empty && !tx_busy && !flush;
  assign ovf_set = wr_en && full && !pop && !flush;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_en),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_data),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Sticky overflow; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (ovf_set)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  // Issue FSM: one start pulse per byte, then track the transmitter busy window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= Q_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      wait_cnt <= '0;
    end else begin
      tx_valid <= 1'b0;
      case (state)
        Q_IDLE: begin
          if (pop) begin
            tx_data  <= head;
            tx_valid <= 1'b1;
            wait_cnt <= '0;
            state    <= Q_WAIT_BUSY;
          end
        end
        Q_WAIT_BUSY: begin
          if (tx_busy)
            state <= Q_WAIT_DONE;
          else if (wait_cnt == WAIT_LAST)
            state <= Q_IDLE;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
        Q_WAIT_DONE: begin
          if (!tx_busy)
            state <= Q_IDLE;
        end
        default: state <= Q_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - scoreboard bench for uart_tx_queue
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       tx_busy = 1'b0;
  logic       full, empty, overflow, tx_valid;
  logic [4:0] count;
  logic [7:0] tx_data;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   tx_force = 1'b0;
  bit   tx_ignore = 1'b0;
  int   busy_len = 3;
  int   busy_cnt = 0;
  logic sv = 1'b0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  int   vcyc[$];

  uart_tx_queue #(.DEPTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor and transmitter model: busy rises the cycle after valid
  initial forever begin
    @(negedge clk);
    sv = tx_valid;
    if (sv) begin
      check("valid_width", prev_valid, 1'b0);
      check("busy_at_valid", tx_busy, 1'b0);
      vcyc.push_back(cyc);
      if (exp_q.size() == 0)
        check("unexpected_valid", 1, 0);
      else
        check("tx_data", tx_data, exp_q.pop_front());
    end
    prev_valid = sv;
    @(posedge clk);
    #1;
    if (tx_force) begin
      tx_busy  = 1'b1;
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      tx_busy = (busy_cnt > 0);
      if (sv && !tx_ignore) begin
        tx_busy  = 1'b1;
        busy_cnt = busy_len;
      end
    end
  end

  task automatic drive(input logic we, input logic [7:0] d, input logic fl,
                       input logic oc, input bit acc);
    @(posedge clk); #1;
    wr_en = we; wr_data = d; flush = fl; ovf_clr = oc;
    if (we && acc) exp_q.push_back(d);
    @(posedge clk); #1;
    wr_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic burst(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b1;
      wr_data = 8'(base + i);
      exp_q.push_back(wr_data);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget);
    int k = 0;
    while (tx_busy !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (tx_busy !== lvl) check("busy_wait_timeout", tx_busy, lvl);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (!(exp_q.size() == 0 && tx_busy == 1'b0 && empty) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    wait_busy(1'b0, 200);
    repeat (2) @(negedge clk);
  endtask

  task automatic lat_check(input logic [7:0] b);
    drive(1'b1, b, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_n1_valid", tx_valid, 1'b0);
    check("lat_n1_count", count, 5'd1);
    @(negedge clk);
    check("lat_n2_valid", tx_valid, 1'b1);
    check("lat_n2_data", tx_data, b);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_count", count, 5'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_data", tx_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single byte, latency N+2
    busy_len = 3;
    vcyc.delete();
    lat_check(8'hA5);
    wait_drain(100);
    check("single_empty", empty, 1'b1);
    check("single_pulses", vcyc.size(), 1);

    // burst of 16 with a slow transmitter
    busy_len = 20;
    vcyc.delete();
    burst(8'h00, 16);
    @(negedge clk);
    check("burst_count", count, 5'd15);
    check("burst_full", full, 1'b0);
    wait_drain(1500);
    check("burst_pulses", vcyc.size(), 16);
    check("burst_empty", empty, 1'b1);

    // overflow with transmitter stalled
    busy_len = 3;
    tx_force = 1'b1;
    burst(8'h10, 16);
    @(negedge clk);
    check("fill_count", count, 5'd16);
    check("fill_full", full, 1'b1);
    check("fill_ovf", overflow, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_set", overflow, 1'b1);
    check("ovf_count", count, 5'd16);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("ovf_clr", overflow, 1'b0);
    drive(1'b1, 8'h78, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("ovf_set_beats_clr", overflow, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("ovf_clr2", overflow, 1'b0);

    // push while full coinciding with pop
    tx_force = 1'b0;
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("pp_count", count, 5'd16);
    check("pp_full", full, 1'b1);
    check("pp_ovf", overflow, 1'b0);
    check("pp_valid", tx_valid, 1'b1);
    wait_drain(1500);
    check("pp_empty", empty, 1'b1);

    // flush with simultaneous push
    tx_force = 1'b1;
    burst(8'h30, 5);
    @(negedge clk);
    check("pre_flush_count", count, 5'd5);
    exp_q.delete();
    tx_force = 1'b0;
    vcyc.delete();
    drive(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_count", count, 5'd0);
    check("flush_empty", empty, 1'b1);
    check("flush_ovf", overflow, 1'b0);
    check("flush_valid", tx_valid, 1'b0);
    repeat (6) @(negedge clk);
    check("flush_no_pulse", vcyc.size(), 0);

    // transmitter never acknowledges: WAIT_BUSY times out after 2 cycles
    tx_ignore = 1'b1;
    vcyc.delete();
    burst(8'h5A, 2);
    repeat (8) @(negedge clk);
    check("timeout_pulses", vcyc.size(), 2);
    if (vcyc.size() == 2) check("timeout_gap", vcyc[1] - vcyc[0], 3);
    check("timeout_empty", empty, 1'b1);
    tx_ignore = 1'b0;

    // async reset during WAIT_DONE with bytes queued
    busy_len = 30;
    burst(8'hC0, 4);
    wait_busy(1'b1, 20);
    repeat (3) @(negedge clk);
    check("pre_rst_count", count, 5'd3);
    rst_n = 1'b0;
    #1;
    check("arst_count", count, 5'd0);
    check("arst_valid", tx_valid, 1'b0);
    check("arst_ovf", overflow, 1'b0);
    check("arst_empty", empty, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_busy(1'b0, 60);
    busy_len = 3;
    @(negedge clk);
    lat_check(8'hD1);
    wait_drain(200);
    check("final_empty", empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
